fetch_cache: RTL and testbench

FETCH_CACHE -- requirements
Module: fetch_cache

---
 rtl/fetch_cache_pkg.sv | 43 ++++
 rtl/fetch_cache_array.sv | 60 ++++++
 rtl/fetch_cache.sv | 183 ++++++++++++++++++
 tb/tb_fetch_cache.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_cache_pkg.sv
// fetch_cache_pkg
//   Shared definitions for the instruction fetch cache: refill FSM state
//   encoding, the line-size-independent address field positions, and small
//   helpers for building line addresses and selecting a word from a line.
//   No ports.
package fetch_cache_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;

  // Byte address layout: [1:0] byte, [3:2] word offset, [IDX_LSB +: idx] index,
  // remaining upper bits are the tag. The index width depends on LINES.
  localparam int OFF_LSB = 2;
  localparam int OFF_W   = 2;
  localparam int IDX_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_REFILL    = 2'd3
  } state_e;

  // Line-aligned address of the line containing a word address.
  function automatic logic [31:0] line_base(input logic [31:2] word_addr);
    return {word_addr[31:IDX_LSB], 4'b0000};
  endfunction

  // Word k of a line lives at bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fetch_cache_array.sv
// fetch_cache_array
//   Direct-mapped storage for the fetch cache: per-line valid bit, tag and
//   128-bit data. One asynchronous read port, one synchronous write port.
//   Valid bits reset and can be cleared all at once; tag/data are not reset
//   because a line is only trusted when its valid bit is set.
// Ports:
//   clk, reset        clock, synchronous active-high reset (valid bits only)
//   flush_all         clear every valid bit at this edge
//   rd_idx            read index; rd_valid/rd_tag/rd_line return that line
//   wr_en, wr_idx,
//   wr_tag, wr_line   write a whole line and set its valid bit
module fetch_cache_array
  import fetch_cache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  // A clear and a write never coincide in practice; the write wins if they do.
  always_comb begin
    valid_d = valid_q;
    if (flush_all) valid_d = '0;
    if (wr_en)     valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/fetch_cache.sv
// fetch_cache
//   Direct-mapped instruction fetch cache with 4-word lines. A request is
//   registered when accepted and looked up the following cycle; a hit returns
//   the word in that cycle, a miss stalls the pipeline and refills the line.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cpu_req_valid, cpu_req_addr        fetch request (ignored while stalled)
//   cpu_resp_data, cpu_stall           fetched word, pipeline stall
//   cpu_flush                          one-cycle invalidate-all pulse
//   mem_req_valid/ready, mem_req_addr  line refill request handshake
//   mem_resp_valid, mem_resp_data      one-cycle refill line delivery
//
// state        | meaning
// ST_IDLE      | looking up a registered request, or idle
// ST_MISS_REQ  | presenting refill request until memory accepts it
// ST_MISS_WAIT | waiting for the refill line
// ST_REFILL    | line written; delivering the requested word for one cycle
module fetch_cache
  import fetch_cache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req_valid,
  input  logic [31:0]              cpu_req_addr,
  output logic [31:0]              cpu_resp_data,
  output logic                     cpu_stall,
  input  logic                     cpu_flush,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [LINE_WORDS*32-1:0] mem_resp_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_LSB - IDX_W;

  state_e        state_q, state_d;
  logic          req_valid_q, req_valid_d;
  logic [31:2]   req_addr_q, req_addr_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic [31:0]   mem_req_addr_q, mem_req_addr_d;
  logic          flush_pend_q, flush_pend_d;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [31:0]       hit_word;
  logic              lookup;
  logic              hit;
  logic              accept;
  logic              flush_all;
  logic              wr_en;
  logic              unused_byte_bits;

  // Byte-within-word bits carry no information for instruction fetch.
  assign unused_byte_bits = ^cpu_req_addr[1:0];

  assign req_off = req_addr_q[OFF_LSB+OFF_W-1:OFF_LSB];
  assign req_idx = req_addr_q[IDX_LSB+IDX_W-1:IDX_LSB];
  assign req_tag = req_addr_q[31:IDX_LSB+IDX_W];

  fetch_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .flush_all (flush_all),
    .rd_idx    (req_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_idx    (req_idx),
    .wr_tag    (req_tag),
    .wr_line   (mem_resp_data)
  );

  assign lookup   = (state_q == ST_IDLE) && req_valid_q;
  assign hit      = lookup && rd_valid && (rd_tag == req_tag);
  assign hit_word = pick_word(rd_line, req_off);

  // The miss is known in the lookup cycle, so the stall must be combinational
  // there; afterwards the state alone decides.
  assign cpu_stall = (lookup && !hit)
                  || (state_q == ST_MISS_REQ)
                  || (state_q == ST_MISS_WAIT);

  // A hit forwards straight from the array; otherwise the last delivered word
  // is held so the output only changes when a new request is answered.
  assign cpu_resp_data = hit ? hit_word : resp_data_q;

  assign accept = cpu_req_valid && !cpu_stall;

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

  always_comb begin
    state_d         = state_q;
    req_valid_d     = accept;
    req_addr_d      = accept ? cpu_req_addr[31:2] : req_addr_q;
    resp_data_d     = resp_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    flush_pend_d    = flush_pend_q;
    flush_all       = 1'b0;
    wr_en           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Clearing here still lets a request registered at this edge be
        // looked up against the emptied array next cycle.
        if (cpu_flush) flush_all = 1'b1;
        if (lookup) begin
          if (hit) begin
            resp_data_d = hit_word;
          end else begin
            state_d         = ST_MISS_REQ;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = line_base(req_addr_q);
          end
        end
      end

      ST_MISS_REQ: begin
        if (cpu_flush) flush_pend_d = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_MISS_WAIT;
        end
      end

      ST_MISS_WAIT: begin
        if (cpu_flush) flush_pend_d = 1'b1;
        if (mem_resp_valid) begin
          wr_en       = 1'b1;
          resp_data_d = pick_word(mem_resp_data, req_off);
          state_d     = ST_REFILL;
        end
      end

      ST_REFILL: begin
        // A deferred flush also wipes the line just refilled; the word has
        // already been captured for delivery this cycle.
        if (cpu_flush || flush_pend_q) flush_all = 1'b1;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      req_valid_q     <= 1'b0;
      req_addr_q      <= '0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      flush_pend_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_valid_q     <= req_valid_d;
      req_addr_q      <= req_addr_d;
      resp_data_q     <= resp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      flush_pend_q    <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_cache.sv
module tb_fetch_cache;

  typedef struct packed {
    logic [31:0] data;
    logic        miss;
    logic [31:0] maddr;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_resp_data;
  logic         cpu_stall;
  logic         cpu_flush;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  localparam logic [127:0] L1 = {32'h33333333, 32'hCAFEF00D, 32'hDEADBEEF, 32'h11111111};
  localparam logic [127:0] L2 = {32'h2000000C, 32'h20000008, 32'h20000004, 32'h20000000};
  localparam logic [127:0] L3 = {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
  localparam logic [127:0] L4 = {32'h0C0C0C0C, 32'h08080808, 32'h04040404, 32'h0BADC0DE};

  fetch_cache #(.LINES(64), .LINE_WORDS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_resp_data  (cpu_resp_data),
    .cpu_stall      (cpu_stall),
    .cpu_flush      (cpu_flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  // ---------------- checking helpers (monitor only) ----------------
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic m,
                      input logic [31:0] ma, input logic fl);
    exp_t e;
    if (cpu_stall) begin
      $display("FAIL send_busy: cpu_stall high when issuing 0x%08h", a);
      $fatal(1);
    end
    e.data = d;
    e.miss = m;
    e.maddr = ma;
    exp_q.push_back(e);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    cpu_flush     = fl;
    tick();
    cpu_req_valid = 1'b0;
    cpu_flush     = 1'b0;
  endtask

  task automatic serve(input logic [127:0] line, input int bp, input bit fl);
    int n;
    n = 0;
    while (!mem_req_valid) begin
      tick();
      n++;
      if (n > 20) begin
        $display("FAIL mem_req_timeout: mem_req_valid never rose");
        $fatal(1);
      end
    end
    mem_req_ready = 1'b0;
    repeat (bp) tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    if (fl) begin
      cpu_flush = 1'b1;
      tick();
      cpu_flush = 1'b0;
    end
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = line;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tick();
  endtask

  // ---------------- driver ----------------
  initial begin
    reset          = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_req_addr   = '0;
    cpu_flush      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // cold miss
    send(32'h00001004, 32'hDEADBEEF, 1'b1, 32'h00001000, 1'b0);
    serve(L1, 2, 1'b0);
    // hits
    send(32'h00001008, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0); tick();
    send(32'h0000100C, 32'h33333333, 1'b0, 32'h0, 1'b0); tick();
    // stray refill data in IDLE must not touch the array
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hBAD0BAD0}};
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    send(32'h00001008, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0); tick();
    // conflict on index 0 with 5 cycles of backpressure
    send(32'h00002000, 32'h20000000, 1'b1, 32'h00002000, 1'b0);
    serve(L2, 5, 1'b0);
    send(32'h00001000, 32'h11111111, 1'b1, 32'h00001000, 1'b0);
    serve(L1, 0, 1'b0);
    send(32'h00001004, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0); tick();
    // flush while idle
    cpu_flush = 1'b1;
    tick();
    cpu_flush = 1'b0;
    send(32'h00001004, 32'hDEADBEEF, 1'b1, 32'h00001000, 1'b0);
    serve(L1, 0, 1'b0);
    // flush in the same cycle as an accepted request
    send(32'h00001008, 32'hCAFEF00D, 1'b1, 32'h00001000, 1'b1);
    serve(L1, 1, 1'b0);
    // flush during MISS_WAIT: word still delivered, everything invalid after
    send(32'h00003010, 32'h77777777, 1'b1, 32'h00003010, 1'b0);
    serve(L3, 0, 1'b1);
    send(32'h00003014, 32'h66666666, 1'b1, 32'h00003010, 1'b0);
    serve(L3, 0, 1'b0);
    send(32'h00001008, 32'hCAFEF00D, 1'b1, 32'h00001000, 1'b0);
    serve(L1, 0, 1'b0);
    // reset in MISS_WAIT, then a late refill pulse
    send(32'h00005000, 32'h0, 1'b1, 32'h00005000, 1'b0);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = L1;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tick();
    send(32'h00000000, 32'h0BADC0DE, 1'b1, 32'h00000000, 1'b0);
    serve(L4, 0, 1'b0);
    send(32'h00000008, 32'h08080808, 1'b0, 32'h0, 1'b0); tick();

    tick();
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t cur;
    bit   outst;
    bit   first;
    int   rst_n;
    cur   = '0;
    outst = 1'b0;
    first = 1'b0;
    rst_n = 0;
    while (!done) begin
      @(negedge clk);
      if (reset) begin
        rst_n++;
        outst = 1'b0;
        if (rst_n >= 2) begin
          chk1 ("rst_stall",     cpu_stall,     1'b0);
          chk1 ("rst_mreq_vld",  mem_req_valid, 1'b0);
          chk32("rst_resp_data", cpu_resp_data, 32'h0);
          chk32("rst_mreq_addr", mem_req_addr,  32'h0);
        end
      end else begin
        rst_n = 0;
        if (mem_req_valid) begin
          chk1 ("mreq_expected", outst && cur.miss, 1'b1);
          chk32("mreq_addr",     mem_req_addr,      cur.maddr);
          chk1 ("mreq_stall",    cpu_stall,         1'b1);
        end
        if (outst) begin
          if (first) begin
            chk1("lookup_miss", cpu_stall, cur.miss);
            first = 1'b0;
          end
          if (!cpu_stall) begin
            chk32("resp_data", cpu_resp_data, cur.data);
            if (!cur.miss) chk1("hit_no_mreq", mem_req_valid, 1'b0);
            outst = 1'b0;
          end
        end
        if (cpu_req_valid && !cpu_stall) begin
          if (exp_q.size() == 0) begin
            chk1("unexpected_accept", 1'b1, 1'b0);
          end else begin
            cur   = exp_q.pop_front();
            outst = 1'b1;
            first = 1'b1;
          end
        end
      end
    end
    chk1("drained", (exp_q.size() == 0) && !outst, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
